// File: rtl/beat_seq_ctrl_if.sv
// Control/status bundle between the beat sequencer and its front panel/datapath.
// The mode/step signals exist only when STEP_MODE_EN is defined.
interface beat_seq_ctrl_if #(
  parameter int CYC_W = 4
);
  logic             start;
  logic             stop;
`ifdef STEP_MODE_EN
  logic             mode;
  logic             step;
`endif
  logic             T1;
  logic             T2;
  logic             T3;
  logic             T4;
  logic             busy;
  logic [CYC_W-1:0] cyc_cnt;
  logic             cyc_end;

`ifdef STEP_MODE_EN
  modport master (output start, stop, mode, step,
                  input  T1, T2, T3, T4, busy, cyc_cnt, cyc_end);
  modport slave  (input  start, stop, mode, step,
                  output T1, T2, T3, T4, busy, cyc_cnt, cyc_end);
`else
  modport master (output start, stop,
                  input  T1, T2, T3, T4, busy, cyc_cnt, cyc_end);
  modport slave  (input  start, stop,
                  output T1, T2, T3, T4, busy, cyc_cnt, cyc_end);
`endif
endinterface

// File: rtl/beat_seq_ctrl.sv
// Run/stop controller and T1..T4 beat ring sequencer with machine-cycle counter.
// Optional single-machine-cycle stepping (WAIT state) is enabled by defining STEP_MODE_EN.
module beat_seq_ctrl #(
  parameter int CYC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  beat_seq_ctrl_if.slave  bus
);

`ifdef STEP_MODE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WAIT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

  state_t           state_q,     state_d;
  logic [3:0]       t_q,         t_d;
  logic [CYC_W-1:0] cnt_q,       cnt_d;
  logic             busy_q,      busy_d;
  logic             cyc_end_q,   cyc_end_d;
  logic             stop_pend_q, stop_pend_d;
  logic             start_q,     start_d;
  logic             start_arm_q, start_arm_d;
  logic             start_rise;
`ifdef STEP_MODE_EN
  logic             step_q,      step_d;
  logic             step_rise;
`endif

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    start_d     = bus.start;
    // start_q is cleared by reset, so a start held through reset must be seen low before it can count as a rise
    start_arm_d = start_arm_q | ~bus.start;
    start_rise  = bus.start & ~start_q & start_arm_q;
`ifdef STEP_MODE_EN
    step_d      = bus.step;
    step_rise   = bus.step & ~step_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_rise && !bus.stop) begin
          state_d = RUN;
          t_d     = 4'b0001;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (t_q[3]) begin
          cnt_d = cnt_q + 1'b1;
          if (stop_pend_q || bus.stop) begin
            state_d     = IDLE;
            t_d         = 4'b0000;
            stop_pend_d = 1'b0;
          end
`ifdef STEP_MODE_EN
          else if (bus.mode) begin
            state_d = WAIT;
            t_d     = 4'b0000;
          end
`endif
          else begin
            t_d = 4'b0001;
          end
        end else begin
          t_d = {t_q[2:0], 1'b0};
          if (bus.stop) stop_pend_d = 1'b1;
        end
      end
`ifdef STEP_MODE_EN
      WAIT: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (step_rise) begin
          state_d = RUN;
          t_d     = 4'b0001;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        t_d     = 4'b0000;
      end
    endcase

    busy_d    = (state_d == RUN);
    cyc_end_d = t_d[3];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      t_q         <= 4'b0000;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      cyc_end_q   <= 1'b0;
      stop_pend_q <= 1'b0;
      start_q     <= 1'b0;
      start_arm_q <= 1'b0;
`ifdef STEP_MODE_EN
      step_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      cyc_end_q   <= cyc_end_d;
      stop_pend_q <= stop_pend_d;
      start_q     <= start_d;
      start_arm_q <= start_arm_d;
`ifdef STEP_MODE_EN
      step_q      <= step_d;
`endif
    end
  end

  assign bus.T1      = t_q[0];
  assign bus.T2      = t_q[1];
  assign bus.T3      = t_q[2];
  assign bus.T4      = t_q[3];
  assign bus.busy    = busy_q;
  assign bus.cyc_cnt = cnt_q;
  assign bus.cyc_end = cyc_end_q;

endmodule

// File: tb/tb_beat_seq_ctrl.sv
// Randomized self-checking bench for beat_seq_ctrl against a cycle-level behavioural model.
// Step-mode scenarios are compiled in when STEP_MODE_EN is defined.
module tb_beat_seq_ctrl;
  localparam int CYC_W = 2;

  logic clk = 1'b0;
  logic rst;
  logic start, stop, mode, step;

  always #5 clk = ~clk;

  beat_seq_ctrl_if #(.CYC_W(CYC_W)) bus ();

  assign bus.start = start;
  assign bus.stop  = stop;
`ifdef STEP_MODE_EN
  assign bus.mode  = mode;
  assign bus.step  = step;
`endif

  beat_seq_ctrl #(.CYC_W(CYC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: running/waiting flags, current beat number 1..4, cycle count
  bit m_run, m_wait, m_pend, m_start_prev, m_step_prev, m_start_low_seen;
  int m_beat, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_wait = 0; m_pend = 0;
    m_start_prev = 0; m_step_prev = 0; m_start_low_seen = 0;
    m_beat = 0; m_cnt = 0;
  endfunction

  function automatic void model_step();
    bit s_rise, p_rise, eff_mode, eff_step;
`ifdef STEP_MODE_EN
    eff_mode = mode; eff_step = step;
`else
    eff_mode = 0; eff_step = 0;
`endif
    s_rise = start && !m_start_prev && m_start_low_seen;
    p_rise = eff_step && !m_step_prev;
    if (m_run) begin
      if (m_beat == 4) begin
        m_cnt = (m_cnt + 1) % (1 << CYC_W);
        if (m_pend || stop) begin
          m_run = 0; m_pend = 0;
        end else if (eff_mode) begin
          m_run = 0; m_wait = 1;
        end else begin
          m_beat = 1;
        end
      end else begin
        m_beat = m_beat + 1;
        if (stop) m_pend = 1;
      end
    end else if (m_wait) begin
      if (stop) m_wait = 0;
      else if (p_rise) begin m_wait = 0; m_run = 1; m_beat = 1; end
    end else if (s_rise && !stop) begin
      m_run = 1; m_beat = 1; m_cnt = 0;
    end
    if (!start) m_start_low_seen = 1;
    m_start_prev = start;
    m_step_prev  = eff_step;
  endfunction

  task automatic check_all(input string tag);
    logic [3:0] exp_t;
    exp_t = m_run ? (4'b0001 << (m_beat - 1)) : 4'b0000;
    chk({tag, ".beats"},   {bus.T4, bus.T3, bus.T2, bus.T1}, exp_t);
    chk({tag, ".busy"},    bus.busy, m_run);
    chk({tag, ".cyc_cnt"}, bus.cyc_cnt, m_cnt);
    chk({tag, ".cyc_end"}, bus.cyc_end, (m_run && m_beat == 4));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  // Called 1 time unit after an edge: asserts reset between edges and releases it before the next one
  task automatic async_reset(input string tag);
    #3 rst = 1'b0;
    model_reset();
    #1 check_all(tag);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; step = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    rst = 1'b1;

    run("idle", 2);
    start = 1'b1;
    run("cont", 22);
    stop = 1'b1;
    cyc("stop_t");
    stop = 1'b0;
    run("stop_drain", 8);
    chk("stop_idle", bus.busy, 1'b0);

    start = 1'b0; cyc("restart_lo");
    start = 1'b1; run("restart", 6);
    async_reset("rst_mid");
    run("rst_hold", 8);
    chk("rst_hold_idle", bus.busy, 1'b0);
    start = 1'b0; cyc("rearm_lo");
    start = 1'b1; run("rearm", 7);

    start = 1'b0; stop = 1'b1; run("stop_all", 6);
    start = 1'b1; cyc("start_and_stop");
    stop = 1'b0; run("start_stop_idle", 3);

`ifdef STEP_MODE_EN
    start = 1'b0; cyc("step_lo");
    mode = 1'b1; start = 1'b1;
    run("step_first", 8);
    chk("wait_idle_out", bus.busy, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step = 1'b1; run("step_go", 6);
      step = 1'b0; cyc("step_lo");
    end
    stop = 1'b1; cyc("wait_stop");
    stop = 1'b0; step = 1'b1; run("after_wait_stop", 4);
    step = 1'b0; mode = 1'b0;
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 15) start = ~start;
      stop = ($urandom_range(0, 24) == 0);
`ifdef STEP_MODE_EN
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      step = ($urandom_range(0, 3) == 0);
`endif
      if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
      cyc("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
